// File: rtl/fault_injector.sv
// fault_injector: scheduled single-bit fault injection on a data path.
// Each fault waits interval+1 cycles, advances the external LFSR, samples
// an address and a one-hot bit mask from it, then holds the flip for
// max(duration,1) cycles. A campaign runs num_faults faults and pulses done.
// Ports:
//   clk, rst_i (async, active-high)
//   start_i, stop_i, num_faults_i, interval_i, duration_i : campaign control
//   lfsr_i / lfsr_en_o                                   : LFSR value / advance
//   data_i / data_o                                      : clean / faulted data
//   fault_addr_o, fault_mask_o, fault_valid_o            : active fault
//   busy_o, done_o, fault_cnt_o                          : campaign status
module fault_injector #(
  parameter int unsigned N_bits = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [7:0]        num_faults_i,
  input  logic [7:0]        interval_i,
  input  logic [3:0]        duration_i,
  input  logic [N_bits-1:0] lfsr_i,
  output logic              lfsr_en_o,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic [DATA_W-1:0] fault_mask_o,
  output logic              fault_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        fault_cnt_o
);

  localparam int unsigned SEL_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_INJECT,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [7:0]          r_num_q;
  logic [7:0]          r_interval_q;
  logic [3:0]          r_duration_q;
  logic [7:0]          r_cnt;
  logic [7:0]          r_fault_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_mask;

  logic [3:0]          w_dur_eff;
  logic                w_wait_last;
  logic                w_inj_last;
  logic                w_last_fault;
  logic [DATA_W-1:0]   w_mask;

  // A zero duration still injects for one cycle.
  assign w_dur_eff    = (r_duration_q == 4'd0) ? 4'd1 : r_duration_q;
  assign w_wait_last  = (r_cnt == r_interval_q);
  assign w_inj_last   = (r_cnt == {4'd0, w_dur_eff - 4'd1});
  assign w_last_fault = ((r_fault_cnt + 8'd1) == r_num_q);

  always_comb begin
    w_mask = '0;
    w_mask[lfsr_i[SEL_W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    lfsr_en_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i)
          w_next = (num_faults_i == 8'd0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (stop_i) w_next = ST_IDLE;
        else if (w_wait_last) begin
          lfsr_en_o = 1'b1;
          w_next    = ST_SAMPLE;
        end
      end
      ST_SAMPLE: w_next = stop_i ? ST_IDLE : ST_INJECT;
      ST_INJECT: begin
        if (stop_i) w_next = ST_IDLE;
        else if (w_inj_last) w_next = w_last_fault ? ST_DONE : ST_WAIT;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_num_q      <= '0;
      r_interval_q <= '0;
      r_duration_q <= '0;
      r_cnt        <= '0;
      r_fault_cnt  <= '0;
      r_addr       <= '0;
      r_mask       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            r_num_q      <= num_faults_i;
            r_interval_q <= interval_i;
            r_duration_q <= duration_i;
            r_fault_cnt  <= '0;
            r_cnt        <= '0;
          end
        end
        ST_WAIT: r_cnt <= w_wait_last ? 8'd0 : r_cnt + 8'd1;
        ST_SAMPLE: begin
          if (!stop_i) begin
            r_addr <= lfsr_i[N_bits-1 -: ADDR_W];
            r_mask <= w_mask;
            r_cnt  <= '0;
          end
        end
        ST_INJECT: begin
          if (!stop_i) begin
            if (w_inj_last) begin
              r_cnt       <= '0;
              r_fault_cnt <= r_fault_cnt + 8'd1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fault_valid_o = (r_state == ST_INJECT);
  assign busy_o        = (r_state == ST_WAIT) || (r_state == ST_SAMPLE) ||
                         (r_state == ST_INJECT);
  assign done_o        = (r_state == ST_DONE);
  assign fault_addr_o  = r_addr;
  assign fault_mask_o  = r_mask;
  assign fault_cnt_o   = r_fault_cnt;
  assign data_o        = data_i ^ (fault_valid_o ? r_mask : '0);

endmodule

// File: tb/tb_fault_injector.sv
module tb_fault_injector;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stop_i;
  logic [7:0]  num_faults_i;
  logic [7:0]  interval_i;
  logic [3:0]  duration_i;
  logic [7:0]  lfsr_i;
  logic        lfsr_en_o;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [2:0]  fault_addr_o;
  logic [31:0] fault_mask_o;
  logic        fault_valid_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  fault_cnt_o;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  fault_injector #(.N_bits(8), .DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .num_faults_i(num_faults_i), .interval_i(interval_i), .duration_i(duration_i),
    .lfsr_i(lfsr_i), .lfsr_en_o(lfsr_en_o), .data_i(data_i), .data_o(data_o),
    .fault_addr_o(fault_addr_o), .fault_mask_o(fault_mask_o),
    .fault_valid_o(fault_valid_o), .busy_o(busy_o), .done_o(done_o),
    .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lfsr_en_o) en_cnt <= en_cnt + 1;
    if (done_o)    done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    num_faults_i = 8'd0; interval_i = 8'd0; duration_i = 4'd0;
    lfsr_i = 8'h00; data_i = 32'hDEAD_BEEF;
    tick(); tick();
    checks++;
    if ({lfsr_en_o, fault_valid_o, busy_o, done_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, want 0000", {lfsr_en_o, fault_valid_o, busy_o, done_o});
    end
    checks++;
    if ({fault_addr_o, fault_mask_o, fault_cnt_o} !== 43'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h mask=%h cnt=%h, want 0", fault_addr_o, fault_mask_o, fault_cnt_o);
    end
    checks++;
    if (data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL reset_data: got %h, want deadbeef", data_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_fault();
    int d0;
    d0 = done_cnt;
    data_i = 32'h1234_5678; lfsr_i = 8'h00;
    num_faults_i = 8'd1; interval_i = 8'd2; duration_i = 4'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lfsr_en_o !== (i == 2) || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL single_wait%0d: en=%b busy=%b, want en=%b busy=1", i, lfsr_en_o, busy_o, (i == 2));
      end
      if (i == 2) lfsr_i = 8'hAA;
      tick();
    end
    checks++;
    if (fault_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_sample: valid=%b busy=%b, want 0/1", fault_valid_o, busy_o);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fault_valid_o !== 1'b1 || fault_addr_o !== 3'b101 || fault_mask_o !== 32'h0000_0400 ||
          data_o !== 32'h1234_5278) begin
        errors++;
        $display("FAIL single_inject%0d: valid=%b addr=%b mask=%h data=%h, want 1/101/00000400/12345278",
                 i, fault_valid_o, fault_addr_o, fault_mask_o, data_o);
      end
      tick();
    end
    checks++;
    if (done_o !== 1'b1 || fault_cnt_o !== 8'd1 || fault_valid_o !== 1'b0 || data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL single_done: done=%b cnt=%0d valid=%b data=%h, want 1/1/0/12345678",
               done_o, fault_cnt_o, fault_valid_o, data_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || (done_cnt - d0) !== 1) begin
      errors++;
      $display("FAIL single_idle: done=%b busy=%b pulses=%0d, want 0/0/1", done_o, busy_o, done_cnt - d0);
    end
  endtask

  task automatic test_multi_fault();
    int d0;
    d0 = done_cnt;
    lfsr_i = 8'h03; data_i = 32'h0000_0000;
    num_faults_i = 8'd4; interval_i = 8'd0; duration_i = 4'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      checks++;
      if (fault_valid_o !== (i % 3 == 0 && i <= 12) || done_o !== (i == 13)) begin
        errors++;
        $display("FAIL multi_cycle%0d: valid=%b done=%b, want %b/%b",
                 i, fault_valid_o, done_o, (i % 3 == 0 && i <= 12), (i == 13));
      end
      if (i == 3) begin
        checks++;
        if (data_o !== 32'h0000_0008) begin
          errors++;
          $display("FAIL multi_data: got %h, want 00000008", data_o);
        end
      end
      tick();
    end
    checks++;
    if (fault_cnt_o !== 8'd4 || (done_cnt - d0) !== 1) begin
      errors++;
      $display("FAIL multi_count: cnt=%0d pulses=%0d, want 4/1", fault_cnt_o, done_cnt - d0);
    end
  endtask

  task automatic test_zero_faults();
    int e0;
    e0 = en_cnt;
    num_faults_i = 8'd0; interval_i = 8'd1; duration_i = 4'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b, want 1/0", done_o, busy_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 1'b0 || (en_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL zero_after: done=%b lfsr_en pulses=%0d, want 0/0", done_o, en_cnt - e0);
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    num_faults_i = 8'd3; interval_i = 8'd1; duration_i = 4'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    // cycles: WAIT, WAIT, SAMPLE, INJECT, then the 2nd WAIT
    tick(); tick(); tick(); tick();
    checks++;
    if (busy_o !== 1'b1 || fault_cnt_o !== 8'd1 || fault_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: busy=%b cnt=%0d valid=%b, want 1/1/0", busy_o, fault_cnt_o, fault_valid_o);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || fault_cnt_o !== 8'd1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b cnt=%0d done=%b, want 0/1/0", busy_o, fault_cnt_o, done_o);
    end
    tick(); tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || (done_cnt - d0) !== 0) begin
      errors++;
      $display("FAIL abort_nodone: busy=%b pulses=%0d, want 0/0", busy_o, done_cnt - d0);
    end
    num_faults_i = 8'd1; interval_i = 8'd0; duration_i = 4'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || fault_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL abort_restart: busy=%b cnt=%0d, want 1/0", busy_o, fault_cnt_o);
    end
    tick(); tick(); tick();
    checks++;
    if (done_o !== 1'b1 || fault_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL abort_restart_done: done=%b cnt=%0d, want 1/1", done_o, fault_cnt_o);
    end
    tick();
  endtask

  task automatic test_collision();
    num_faults_i = 8'd2; interval_i = 8'd0; duration_i = 4'd4;
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL collide_idle: busy=%b, want 0", busy_o);
    end
    num_faults_i = 8'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    // cycle 1 WAIT, 2 SAMPLE, 3..6 INJECT, 7 DONE
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) begin
        start_i = 1'b1; num_faults_i = 8'd5; interval_i = 8'd9; duration_i = 4'd1;
      end
      if (i == 5) start_i = 1'b0;
      checks++;
      if (fault_valid_o !== (i >= 3 && i <= 6) || done_o !== (i == 7)) begin
        errors++;
        $display("FAIL collide_cycle%0d: valid=%b done=%b, want %b/%b",
                 i, fault_valid_o, done_o, (i >= 3 && i <= 6), (i == 7));
      end
      tick();
    end
    checks++;
    if (busy_o !== 1'b0 || fault_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL collide_end: busy=%b cnt=%0d, want 0/1", busy_o, fault_cnt_o);
    end
  endtask

  task automatic test_reset_mid_inject();
    int d0;
    d0 = done_cnt;
    lfsr_i = 8'h1F; data_i = 32'h0F0F_0F0F;
    num_faults_i = 8'd2; interval_i = 8'd0; duration_i = 4'd5; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    checks++;
    if (fault_valid_o !== 1'b1 || data_o !== 32'h8F0F_0F0F) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b data=%h, want 1/8f0f0f0f", fault_valid_o, data_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (fault_valid_o !== 1'b0 || data_o !== 32'h0F0F_0F0F || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_now: valid=%b data=%h busy=%b, want 0/0f0f0f0f/0", fault_valid_o, data_o, busy_o);
    end
    checks++;
    if ({fault_addr_o, fault_mask_o, fault_cnt_o} !== 43'd0) begin
      errors++;
      $display("FAIL rstmid_regs: addr=%h mask=%h cnt=%h, want 0", fault_addr_o, fault_mask_o, fault_cnt_o);
    end
    tick();
    rst_i = 1'b0;
    tick(); tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || (done_cnt - d0) !== 0) begin
      errors++;
      $display("FAIL rstmid_after: done=%b busy=%b pulses=%0d, want 0/0/0", done_o, busy_o, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_multi_fault();
    test_zero_faults();
    test_abort();
    test_collision();
    test_reset_mid_inject();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
